// File: rtl/paper_pkg.sv
// -----------------------------------------------------------------------------
// paper_pkg
// Shared definitions for the paper_core processor: the four opcodes and the
// sequencer state encoding.
// -----------------------------------------------------------------------------
package paper_pkg;

  // Opcode field values (upper two bits of the instruction word).
  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_JNO  = 2'b01;
  localparam logic [1:0] OP_CLRS = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

endpackage : paper_pkg

// File: rtl/paper_if.sv
// -----------------------------------------------------------------------------
// paper_if
// Control/observation bundle of paper_core.
//   start      1-cycle pulse: begin or restart execution at address 0
//   load_en    program memory write strobe
//   load_addr  program memory write address
//   load_data  instruction word to write
//   pc         current program counter
//   instr      instruction register (last fetched word)
//   acc        accumulator
//   status     sticky overflow flag
//   busy       high while fetching/executing
//   halted     high once a HALT has executed
// The master side drives start/load; the slave side (the core) drives the rest.
// -----------------------------------------------------------------------------
interface paper_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3
);
  localparam int INSTR_W = 2 + ADDR_W;

  logic               start;
  logic               load_en;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_data;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] instr;
  logic [DATA_W-1:0]  acc;
  logic               status;
  logic               busy;
  logic               halted;

  modport master (
    output start, load_en, load_addr, load_data,
    input  pc, instr, acc, status, busy, halted
  );

  modport slave (
    input  start, load_en, load_addr, load_data,
    output pc, instr, acc, status, busy, halted
  );

endinterface : paper_if

// File: rtl/paper_imem.sv
// -----------------------------------------------------------------------------
// paper_imem
// Program memory: 2**ADDR_W words of INSTR_W bits, synchronous write,
// asynchronous (combinational) read.
//   clock  write clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (follows raddr combinationally)
// -----------------------------------------------------------------------------
module paper_imem #(
  parameter int ADDR_W  = 3,
  parameter int INSTR_W = 5
) (
  input  logic               clock,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [INSTR_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset on purpose -- the program must survive
  // reset_n, and an unreset array maps onto plain RAM/register-file cells.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : paper_imem

// File: rtl/paper_core.sv
// -----------------------------------------------------------------------------
// paper_core
// Accumulator processor with sticky overflow status, program memory, program
// counter and a FETCH/EXEC sequencer. Every instruction takes two cycles.
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset (program memory is not reset)
//   bus      paper_if slave: start/load inputs, architectural state outputs
// -----------------------------------------------------------------------------
module paper_core
  import paper_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3
) (
  input  logic    clock,
  input  logic    reset_n,
  paper_if.slave  bus
);

  localparam int INSTR_W = 2 + ADDR_W;

  state_t             state_q, state_n;
  logic [ADDR_W-1:0]  pc_q, pc_n;
  logic [INSTR_W-1:0] instr_q, instr_n;
  logic [DATA_W-1:0]  acc_q, acc_n;
  logic               status_q, status_n;
  logic               busy_q, halted_q;

  logic               mem_we;
  logic [INSTR_W-1:0] mem_rdata;

  logic [1:0]         opcode;
  logic [ADDR_W-1:0]  target;
  logic [ADDR_W-1:0]  pc_inc;
  logic [DATA_W:0]    acc_sum;

  assign opcode  = instr_q[INSTR_W-1:ADDR_W];
  assign target  = instr_q[ADDR_W-1:0];
  // Natural wrap of the ADDR_W-bit sum gives modulo-2**ADDR_W sequencing.
  assign pc_inc  = pc_q + ADDR_W'(1);
  // One extra bit catches the carry out of the accumulator.
  assign acc_sum = {1'b0, acc_q} + (DATA_W + 1)'(1);

  paper_imem #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_imem (
    .clock (clock),
    .we    (mem_we),
    .waddr (bus.load_addr),
    .wdata (bus.load_data),
    .raddr (pc_q),
    .rdata (mem_rdata)
  );

  // NOTE: every signal gets its hold value first so no path leaves one
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_n  = state_q;
    pc_n     = pc_q;
    instr_n  = instr_q;
    acc_n    = acc_q;
    status_n = status_q;
    mem_we   = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALTED: begin
        // A load takes priority over a start arriving in the same cycle.
        if (bus.load_en) begin
          mem_we = 1'b1;
        end else if (bus.start) begin
          state_n  = ST_FETCH;
          pc_n     = '0;
          acc_n    = '0;
          status_n = 1'b0;
        end
      end

      ST_FETCH: begin
        instr_n = mem_rdata;
        state_n = ST_EXEC;
      end

      ST_EXEC: begin
        state_n = ST_FETCH;
        case (opcode)
          OP_INC: begin
            // Once overflow is flagged the accumulator freezes until CLRS.
            if (!status_q) begin
              {status_n, acc_n} = acc_sum;
            end
            pc_n = pc_inc;
          end
          OP_JNO: begin
            pc_n = status_q ? pc_inc : target;
          end
          OP_CLRS: begin
            status_n = 1'b0;
            pc_n     = pc_inc;
          end
          default: begin // OP_HALT: pc stays on the HALT word
            state_n = ST_HALTED;
          end
        endcase
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      acc_q    <= '0;
      status_q <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      pc_q     <= pc_n;
      instr_q  <= instr_n;
      acc_q    <= acc_n;
      status_q <= status_n;
      // Decoded from the next state so the flags line up with state_q.
      busy_q   <= (state_n == ST_FETCH) || (state_n == ST_EXEC);
      halted_q <= (state_n == ST_HALTED);
    end
  end

  assign bus.pc     = pc_q;
  assign bus.instr  = instr_q;
  assign bus.acc    = acc_q;
  assign bus.status = status_q;
  assign bus.busy   = busy_q;
  assign bus.halted = halted_q;

endmodule : paper_core

// File: doc/paper_core.md
Name: paper_core

Overview:
- Parametrised successor to the 2-bit paper processor: one self-contained core with an accumulator, sticky overflow status, program memory, program counter and sequencer.
- Widens the accumulator and address space, and gives JNO an explicit jump target.
- Adds a CLRS instruction, a program-load port, and a start/halt/restart handshake.
- Replaces the monostable/pulse clocking with a single-clock FETCH/EXEC state machine.

Parameters:
- DATA_W, 4, accumulator width in bits (>=2).
- ADDR_W, 3, program address width; memory depth is 2**ADDR_W.
- INSTR_W, 2+ADDR_W, derived instruction width: opcode in [INSTR_W-1:ADDR_W], target in [ADDR_W-1:0].

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  1-cycle pulse: begin (or restart) execution at address 0.
- load_en  in  1  write strobe for the program memory.
- load_addr  in  ADDR_W  program memory write address.
- load_data  in  INSTR_W  instruction word to write.
- pc  out  ADDR_W  current program counter.
- instr  out  INSTR_W  instruction register, i.e. the last fetched word.
- acc  out  DATA_W  accumulator.
- status  out  1  sticky overflow flag.
- busy  out  1  high in FETCH or EXEC.
- halted  out  1  high in HALTED.

Behaviour:
- Clock and reset:
  - One clock. Reset is asynchronous and active-low.
  - Asserting reset_n=0 forces immediately, regardless of state: state=IDLE, pc=0, instr=0, acc=0, status=0, busy=0, halted=0.
  - Program memory is NOT reset; its contents survive reset.
- States: IDLE, FETCH, EXEC, HALTED.
- IDLE and HALTED:
  - load_en=1 writes mem[load_addr]<=load_data.
  - start=1 goes to FETCH and clears pc, acc and status to 0.
  - If load_en and start are high in the same cycle, the write occurs and start is ignored.
  - HALTED holds pc at the HALT address; acc and status hold.
- FETCH: instr<=mem[pc]; next state EXEC. No architectural state changes other than instr.
- EXEC: decode instr, then return to FETCH unless the opcode is HALT. Each instruction therefore takes exactly 2 cycles.
- Opcodes:
  - 00 INC:
    - If status=0: {carry,acc}<=acc+1 at DATA_W+1 bits, and status<=carry. At acc=all-ones this gives acc=0, status=1.
    - If status=1: acc and status hold.
    - pc<=pc+1.
  - 01 JNO: if status=0, pc<=instr[ADDR_W-1:0]; else pc<=pc+1.
  - 10 CLRS: status<=0; acc unchanged; pc<=pc+1.
  - 11 HALT: next state HALTED; pc unchanged; halted<=1 on the same edge.
- pc arithmetic is modulo 2**ADDR_W: from all-ones it wraps to 0.
- start and load_en are ignored while busy=1.
- busy and halted are registered decodes of state; they are never both 1.

Decomposition:
- Package paper_pkg holds:
  - opcode localparams OP_INC=2'b00, OP_JNO=2'b01, OP_CLRS=2'b10, OP_HALT=2'b11;
  - state encodings ST_IDLE, ST_FETCH, ST_EXEC, ST_HALTED.
- One natural sub-module: paper_imem, the 2**ADDR_W x INSTR_W memory.
  - Synchronous write, asynchronous read.
  - No reset.
  - Parametrised by ADDR_W and INSTR_W.
- The core instantiates paper_imem and contains the FSM, pc, acc/status datapath and instruction register.

Test Plan:
1. Basic run: load 0:INC, 1:INC, 2:HALT; pulse start -> busy for 6 cycles, then halted=1, acc=2, status=0, pc=2.
2. Overflow loop (DATA_W=4): load 0:INC, 1:JNO 0, 2:HALT; start -> HALTED after 66 cycles with acc=0, status=1, pc=2. The status rise must coincide with acc wrapping 15->0.
3. CLRS: load 0:INC, 1:JNO 0, 2:CLRS, 3:INC, 4:HALT -> halted with status=0, acc=1, pc=4. While status=1 before CLRS, an extra INC leaves acc unchanged.
4. PC wrap (ADDR_W=3): load 0:JNO 7, 1:HALT, 7:INC -> pc visits 7->0 repeatedly; on overflow JNO falls through to 1; final acc=0, status=1, pc=1.
5. Reset mid-run: drop reset_n during EXEC of test 1 -> all outputs 0 in the same time step, without waiting for a clock. Release reset and start -> identical result to test 1, proving the program is retained.
6. Handshake guards:
   - load_en and start pulsed while busy -> no memory change and no restart.
   - start in HALTED -> rerun from pc=0 with acc=0.
   - simultaneous load_en+start in IDLE -> write only, state stays IDLE.
